// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one full-subtractor slice
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             d_bit;
    logic             bo;
    logic [WIDTH-1:0] d_sh_next;

    assign d_bit     = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    assign bo        = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    assign d_sh_next = (d_sh_q >> 1) | {d_bit, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_sh_d   = d_sh_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            SHIFT: begin
                d_sh_d = d_sh_next;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = bo;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit: publish the whole word at once so diff never shows partials.
                    diff_d   = d_sh_next;
                    borrow_d = bo;
                    cnt_d    = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
                if (state_q == DONE) state_d = IDLE;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    d_sh_d  = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_sh_q   <= d_sh_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and random checks of serial_subtractor at WIDTH 8 and 4
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       s8, busy8, done8, bor8;
    logic [7:0] a8, b8, d8;
    logic       s4, busy4, done4, bor4;
    logic [3:0] a4, b4, d4;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(d8), .borrow(bor8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(d4), .borrow(bor4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [7:0] ed;
        logic       eb;
        int         cyc;
        ed = a - b;
        eb = (a < b);
        s8 = 1'b1; a8 = a; b8 = b;
        tick;
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        check({tag, " busy"}, 32'(busy8), 32'd1);
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 20) begin
            tick;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd8);
        check({tag, " diff"}, 32'(d8), 32'(ed));
        check({tag, " borrow"}, 32'(bor8), 32'(eb));
        tick;
        check({tag, " done_clear"}, 32'(done8), 32'd0);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] ed;
        logic       eb;
        int         cyc;
        ed = 4'((int'(a) - int'(b) + 16) % 16);
        eb = (int'(a) < int'(b));
        s4 = 1'b1; a4 = a; b4 = b;
        tick;
        s4 = 1'b0;
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 12) begin
            tick;
            cyc++;
        end
        check("w4 latency", 32'(cyc), 32'd4);
        check($sformatf("w4 diff %0h-%0h", a, b), 32'(d4), 32'(ed));
        check($sformatf("w4 borrow %0h-%0h", a, b), 32'(bor4), 32'(eb));
        tick;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         cyc;
        int         pulses;
        logic       hold_ok;
        logic [7:0] seen;
        logic [7:0] ra, rb;

        rst_n = 1'b0;
        s8 = 1'b0; a8 = '0; b8 = '0;
        s4 = 1'b0; a4 = '0; b4 = '0;
        tick;
        tick;
        check("reset diff", 32'(d8), 32'd0);
        check("reset borrow", 32'(bor8), 32'd0);
        check("reset busy", 32'(busy8), 32'd0);
        check("reset done", 32'(done8), 32'd0);
        rst_n = 1'b1;
        tick;

        run8(8'h05, 8'h03, "basic");
        run8(8'h03, 8'h05, "underflow");
        run8(8'h00, 8'hFF, "zero_minus_ff");
        run8(8'hFF, 8'hFF, "ff_minus_ff");
        run8(8'h80, 8'h01, "80_minus_01");
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, "random");
        end

        // A start pulse during SHIFT with new operands must be ignored
        s8 = 1'b1; a8 = 8'h05; b8 = 8'h03;
        tick;
        s8 = 1'b0;
        tick;
        tick;
        s8 = 1'b1; a8 = 8'hAA; b8 = 8'h11;
        tick;
        s8 = 1'b0;
        pulses = 0;
        seen = '0;
        for (int i = 0; i < 15; i++) begin
            if (done8 === 1'b1) begin
                pulses++;
                seen = d8;
            end
            tick;
        end
        check("busy_start pulses", 32'(pulses), 32'd1);
        check("busy_start diff", 32'(seen), 32'h02);

        // Back-to-back with start held high
        s8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
        tick;
        a8 = 8'h01; b8 = 8'h02;
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 20) begin
            tick;
            cyc++;
        end
        check("b2b first latency", 32'(cyc), 32'd8);
        check("b2b first diff", 32'(d8), 32'h0F);
        check("b2b first borrow", 32'(bor8), 32'd0);
        tick;
        s8 = 1'b0;
        check("b2b restart busy", 32'(busy8), 32'd1);
        cyc = 1;
        hold_ok = 1'b1;
        while (done8 !== 1'b1 && cyc < 20) begin
            if (d8 !== 8'h0F) hold_ok = 1'b0;
            tick;
            cyc++;
        end
        check("b2b spacing", 32'(cyc), 32'd9);
        check("b2b diff held", 32'(hold_ok), 32'd1);
        check("b2b second diff", 32'(d8), 32'hFF);
        check("b2b second borrow", 32'(bor8), 32'd1);
        tick;
        check("b2b done clear", 32'(done8), 32'd0);

        // Asynchronous reset in the middle of an operation
        run8(8'h10, 8'h01, "pre_reset");
        s8 = 1'b1; a8 = 8'h05; b8 = 8'h03;
        tick;
        s8 = 1'b0;
        tick;
        tick;
        tick;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset diff", 32'(d8), 32'd0);
        check("midreset borrow", 32'(bor8), 32'd0);
        check("midreset busy", 32'(busy8), 32'd0);
        check("midreset done", 32'(done8), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (done8 === 1'b1) pulses++;
        end
        check("midreset no done", 32'(pulses), 32'd0);
        run8(8'h09, 8'h04, "post_reset");

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run4(4'(x), 4'(y));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
